// File: rtl/mcs4_pkg.sv
// Shared types and constants for the MCS-4 CPU-side bus sequencer.
package mcs4_pkg;

    localparam int NIB_W  = 4;
    localparam int ADDR_W = 12;

    localparam logic [NIB_W-1:0] OPR_IO = 4'hE;

    typedef enum logic [2:0] {
        SC_A1 = 3'd0,
        SC_A2 = 3'd1,
        SC_A3 = 3'd2,
        SC_M1 = 3'd3,
        SC_M2 = 3'd4,
        SC_X1 = 3'd5,
        SC_X2 = 3'd6,
        SC_X3 = 3'd7
    } subcycle_e;

endpackage

// File: rtl/mcs4_phase_gen.sv
// Slot counter, non-overlapping PHI1/PHI2 generation, and the subcycle-wrap
// and data-sample strobes used by the bus sequencer.
module mcs4_phase_gen #(
    parameter int PHASE_LEN = 2
) (
    input  logic clk_i,
    input  logic RESET_N_i,
    output logic wrap_o,
    output logic sample_o,
    output logic phi1_o,
    output logic phi2_o
);

    localparam int SLOTS = 4 * PHASE_LEN;
    localparam int TW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    localparam logic [TW-1:0] T_LAST   = TW'(SLOTS - 1);
    localparam logic [TW-1:0] T_SAMPLE = TW'(3 * PHASE_LEN - 1);
    localparam logic [TW-1:0] P1_END   = TW'(PHASE_LEN);
    localparam logic [TW-1:0] P2_BEG   = TW'(2 * PHASE_LEN);
    localparam logic [TW-1:0] P2_END   = TW'(3 * PHASE_LEN);

    logic          armed_q, armed_d;
    logic [TW-1:0] t_q, t_d;
    logic          phi1_q, phi1_d;
    logic          phi2_q, phi2_d;

    // The first edge after reset release only loads slot-0 outputs, so the
    // opening X3 subcycle is a full-length one with correctly phased clocks.
    always_comb begin
        armed_d = 1'b1;
        t_d     = '0;
        if (armed_q && (t_q != T_LAST)) begin
            t_d = t_q + TW'(1);
        end
        phi1_d = (t_d < P1_END);
        phi2_d = (t_d >= P2_BEG) && (t_d < P2_END);
    end

    always_ff @(posedge clk_i or negedge RESET_N_i) begin
        if (!RESET_N_i) begin
            armed_q <= 1'b0;
            t_q     <= '0;
            phi1_q  <= 1'b0;
            phi2_q  <= 1'b0;
        end else begin
            armed_q <= armed_d;
            t_q     <= t_d;
            phi1_q  <= phi1_d;
            phi2_q  <= phi2_d;
        end
    end

    assign wrap_o   = armed_q && (t_q == T_LAST);
    assign sample_o = armed_q && (t_q == T_SAMPLE);
    assign phi1_o   = phi1_q;
    assign phi2_o   = phi2_q;

endmodule

// File: rtl/mcs4_bus_seq.sv
// MCS-4 CPU-side bus sequencer: subcycle FSM, program counter, D-bus mux and
// OPR/OPA capture. Define MCS4_IO_CM_EN to add the M2 CM strobe and X2 I/O capture.
module mcs4_bus_seq
    import mcs4_pkg::*;
#(
    parameter int                PHASE_LEN = 2,
    parameter logic [ADDR_W-1:0] PC_RESET  = 12'h000
) (
    input  logic              clk_i,
    input  logic              RESET_N_i,
    input  logic              run_i,
    input  logic              pc_load_i,
    input  logic [ADDR_W-1:0] pc_load_val_i,
    input  logic [NIB_W-1:0]  D_i,
    output logic [NIB_W-1:0]  D_o,
    output logic              D_oe_o,
    output logic              PHI1_o,
    output logic              PHI2_o,
    output logic              SYNC_o,
    output logic              CM_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              instr_valid_o,
    output logic [NIB_W-1:0]  opr_o,
    output logic [NIB_W-1:0]  opa_o
`ifdef MCS4_IO_CM_EN
    ,
    output logic [NIB_W-1:0]  io_data_o,
    output logic              io_valid_o
`endif
);

    logic wrap;
    logic sample;

    mcs4_phase_gen #(
        .PHASE_LEN (PHASE_LEN)
    ) u_phase_gen (
        .clk_i     (clk_i),
        .RESET_N_i (RESET_N_i),
        .wrap_o    (wrap),
        .sample_o  (sample),
        .phi1_o    (PHI1_o),
        .phi2_o    (PHI2_o)
    );

    subcycle_e         sub_q, sub_d;
    logic              fetch_q, fetch_d;
    logic              ld_q, ld_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [NIB_W-1:0]  d_q, d_d;
    logic              oe_q, oe_d;
    logic              cm_q, cm_d;
    logic              sync_q, sync_d;
    logic              valid_q, valid_d;
    logic [NIB_W-1:0]  opr_q, opr_d;
    logic [NIB_W-1:0]  opa_q, opa_d;
`ifdef MCS4_IO_CM_EN
    logic [NIB_W-1:0]  io_q, io_d;
    logic              io_v_q, io_v_d;
`endif

    always_comb begin
        sub_d   = sub_q;
        fetch_d = fetch_q;
        ld_d    = ld_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        opr_d   = opr_q;
        opa_d   = opa_q;
        valid_d = 1'b0;
        d_d     = '0;
        oe_d    = 1'b0;
        cm_d    = 1'b0;
`ifdef MCS4_IO_CM_EN
        io_d    = io_q;
        io_v_d  = 1'b0;
`endif

        if (pc_load_i) begin
            tgt_d = pc_load_val_i;
            ld_d  = 1'b1;
        end

        // A load arriving on the boundary clock is folded in via ld_d/tgt_d.
        if (wrap) begin
            sub_d = subcycle_e'(sub_q + 3'd1);
            if (sub_q == SC_X3) begin
                fetch_d = run_i;
                if (ld_d) begin
                    pc_d = tgt_d;
                    ld_d = 1'b0;
                end else if (fetch_q) begin
                    pc_d = pc_q + 12'd1;
                end
            end
        end

        if (sample && fetch_q) begin
            if (sub_q == SC_M1) begin
                opr_d = D_i;
            end
            if (sub_q == SC_M2) begin
                opa_d   = D_i;
                valid_d = 1'b1;
            end
`ifdef MCS4_IO_CM_EN
            if ((sub_q == SC_X2) && (opr_q == OPR_IO)) begin
                io_d   = D_i;
                io_v_d = 1'b1;
            end
`endif
        end

        sync_d = (sub_d == SC_X3);
        if (fetch_d) begin
            case (sub_d)
                SC_A1: begin
                    oe_d = 1'b1;
                    d_d  = pc_d[3:0];
                end
                SC_A2: begin
                    oe_d = 1'b1;
                    d_d  = pc_d[7:4];
                end
                SC_A3: begin
                    oe_d = 1'b1;
                    d_d  = pc_d[11:8];
                    cm_d = 1'b1;
                end
`ifdef MCS4_IO_CM_EN
                SC_M2: cm_d = (opr_d == OPR_IO);
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge RESET_N_i) begin
        if (!RESET_N_i) begin
            sub_q   <= SC_X3;
            fetch_q <= 1'b0;
            ld_q    <= 1'b0;
            pc_q    <= PC_RESET;
            tgt_q   <= '0;
            d_q     <= '0;
            oe_q    <= 1'b0;
            cm_q    <= 1'b0;
            sync_q  <= 1'b0;
            valid_q <= 1'b0;
            opr_q   <= '0;
            opa_q   <= '0;
`ifdef MCS4_IO_CM_EN
            io_q    <= '0;
            io_v_q  <= 1'b0;
`endif
        end else begin
            sub_q   <= sub_d;
            fetch_q <= fetch_d;
            ld_q    <= ld_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            d_q     <= d_d;
            oe_q    <= oe_d;
            cm_q    <= cm_d;
            sync_q  <= sync_d;
            valid_q <= valid_d;
            opr_q   <= opr_d;
            opa_q   <= opa_d;
`ifdef MCS4_IO_CM_EN
            io_q    <= io_d;
            io_v_q  <= io_v_d;
`endif
        end
    end

    assign D_o           = d_q;
    assign D_oe_o        = oe_q;
    assign CM_o          = cm_q;
    assign SYNC_o        = sync_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = valid_q;
    assign opr_o         = opr_q;
    assign opa_o         = opa_q;
`ifdef MCS4_IO_CM_EN
    assign io_data_o     = io_q;
    assign io_valid_o    = io_v_q;
`endif

endmodule

// File: tb/tb_mcs4_bus_seq.sv
// Scoreboard bench for mcs4_bus_seq: a cycle-level PC model queues expected
// instruction cycles; a bus monitor (also acting as ROM) reconstructs each cycle and checks it.
module tb_mcs4_bus_seq;

    localparam logic [11:0] PC_RST = 12'h000;
    localparam int          NCYC   = 40;

    logic        clk_i = 1'b0;
    logic        RESET_N_i;
    logic        run_i;
    logic        pc_load_i;
    logic [11:0] pc_load_val_i;
    logic [3:0]  D_i = 4'h0;
    logic [3:0]  D_o;
    logic        D_oe_o, PHI1_o, PHI2_o, SYNC_o, CM_o, instr_valid_o;
    logic [11:0] pc_o;
    logic [3:0]  opr_o, opa_o;
`ifdef MCS4_IO_CM_EN
    logic [3:0]  io_data_o;
    logic        io_valid_o;
`endif

    always #5 clk_i = ~clk_i;

    mcs4_bus_seq #(
        .PHASE_LEN (2),
        .PC_RESET  (PC_RST)
    ) dut (
        .clk_i         (clk_i),
        .RESET_N_i     (RESET_N_i),
        .run_i         (run_i),
        .pc_load_i     (pc_load_i),
        .pc_load_val_i (pc_load_val_i),
        .D_i           (D_i),
        .D_o           (D_o),
        .D_oe_o        (D_oe_o),
        .PHI1_o        (PHI1_o),
        .PHI2_o        (PHI2_o),
        .SYNC_o        (SYNC_o),
        .CM_o          (CM_o),
        .pc_o          (pc_o),
        .instr_valid_o (instr_valid_o),
        .opr_o         (opr_o),
        .opa_o         (opa_o)
`ifdef MCS4_IO_CM_EN
        ,
        .io_data_o     (io_data_o),
        .io_valid_o    (io_valid_o)
`endif
    );

    int n_total  = 0;
    int n_passed = 0;
    int pushed   = 0;
    int popped   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // ROM contents as seen by the bench
    function automatic logic [3:0] rom_opr(input logic [11:0] a);
        return 4'(a[3:0] + a[7:4] + a[11:8] + 4'hD);
    endfunction
    function automatic logic [3:0] rom_opa(input logic [11:0] a);
        return a[3:0] ^ a[11:8] ^ 4'h4;
    endfunction
    function automatic logic [3:0] rom_io(input logic [11:0] a);
        return a[7:4] ^ 4'h9;
    endfunction

    typedef struct {
        bit          run;
        logic [11:0] addr;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- monitor / ROM ----------------
    int         pos;
    bit         started   = 1'b0;
    bit         prev_sync = 1'b0;
    int         ph_err, bus_err, oe_a, vcnt, vpos, iocnt, iopos;
    int         cm_cnt[8];
    logic [3:0] nib[4];
    logic [3:0] opr_s, opa_s, io_s;

    task automatic clear_obs();
        ph_err = 0; bus_err = 0; oe_a = 0; vcnt = 0; vpos = -1; iocnt = 0; iopos = -1;
        for (int i = 0; i < 8; i++) cm_cnt[i] = 0;
        for (int i = 0; i < 4; i++) nib[i] = 4'h0;
        opr_s = 4'h0; opa_s = 4'h0; io_s = 4'h0;
    endtask

    task automatic finalize();
        exp_t e;
        bit   io_e;
        int   cm_other;
        if (exp_q.size() == 0) begin
            chk("expected_record_available", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        popped++;
        io_e = e.run && (rom_opr(e.addr) == 4'hE);
        cm_other = cm_cnt[0] + cm_cnt[1] + cm_cnt[2] + cm_cnt[4] + cm_cnt[6] + cm_cnt[7];
        chk("sync_period", pos, 63);
        chk("phase_sync_shape", ph_err, 0);
        chk("bus_stray_drive", bus_err, 0);
        chk("addr_drive_clocks", oe_a, e.run ? 24 : 0);
        chk("cm_a3_clocks", cm_cnt[3], e.run ? 8 : 0);
`ifdef MCS4_IO_CM_EN
        chk("cm_m2_clocks", cm_cnt[5], io_e ? 8 : 0);
        chk("io_valid_cnt", iocnt, io_e ? 1 : 0);
        if (io_e) begin
            chk("io_data", io_s, rom_io(e.addr));
            chk("io_valid_pos", iopos, 62);
        end
`else
        chk("cm_m2_clocks", cm_cnt[5], 0);
`endif
        chk("cm_other_clocks", cm_other, 0);
        chk("instr_valid_cnt", vcnt, e.run ? 1 : 0);
        if (e.run) begin
            chk("fetch_addr", {nib[3], nib[2], nib[1]}, e.addr);
            chk("instr_valid_pos", vpos, 46);
            chk("opr", opr_s, rom_opr(e.addr));
            chk("opa", opa_s, rom_opa(e.addr));
        end
    endtask

    always @(negedge clk_i) begin
        int s, t;
        if (!RESET_N_i) begin
            started   = 1'b0;
            prev_sync = 1'b0;
            D_i       = 4'h0;
        end else begin
            if (SYNC_o && !prev_sync) begin
                if (started && pos >= 8) finalize();
                started = 1'b1;
                pos     = 0;
                clear_obs();
            end else if (started) begin
                pos++;
            end
            prev_sync = SYNC_o;
            if (started) begin
                s = (pos / 8) % 8;
                t = pos % 8;
                if (PHI1_o !== (t < 2)) ph_err++;
                if (PHI2_o !== (t >= 4 && t < 6)) ph_err++;
                if (SYNC_o !== (s == 0)) ph_err++;
                if (s >= 1 && s <= 3) begin
                    if (D_oe_o) begin
                        oe_a++;
                        if (t == 0) nib[s] = D_o;
                        else if (D_o !== nib[s]) bus_err++;
                    end
                end else if (D_oe_o !== 1'b0) begin
                    bus_err++;
                end
                if (CM_o) cm_cnt[s]++;
                if (instr_valid_o) begin
                    vcnt++; vpos = pos; opr_s = opr_o; opa_s = opa_o;
                end
`ifdef MCS4_IO_CM_EN
                if (io_valid_o) begin
                    iocnt++; iopos = pos; io_s = io_data_o;
                end
`endif
                // ROM answers only at the sample slot; noise elsewhere
                if (t == 5 && s == 4)      D_i = rom_opr({nib[3], nib[2], nib[1]});
                else if (t == 5 && s == 5) D_i = rom_opa({nib[3], nib[2], nib[1]});
                else if (t == 5 && s == 7) D_i = rom_io({nib[3], nib[2], nib[1]});
                else                       D_i = 4'($urandom);
            end
        end
    end

    // ---------------- stimulus + PC reference model ----------------
    logic [11:0] pc_m, tgt_m;
    bit          lm, run_cur;

    task automatic drive_cycle(input int k);
        bit          run_next;
        int          l1, l2, mode;
        logic [11:0] v1, v2;
        run_next = ($urandom_range(0, 4) != 0);
        l1 = -1; l2 = -1;
        v1 = 12'($urandom); v2 = 12'($urandom);
        mode = $urandom_range(0, 3);
        if (mode == 1) l1 = $urandom_range(0, 63);
        else if (mode == 2) begin l1 = $urandom_range(0, 30); l2 = $urandom_range(31, 63); end
        else if (mode == 3) l1 = 63;
        if (k < 9) begin
            run_next = 1'b1; l1 = -1; l2 = -1;
        end
        if (k == 1) begin l1 = 28; v1 = 12'hABC; end
        if (k == 3) begin l1 = 63; v1 = 12'hFFF; end
        if (k == 5) run_next = 1'b0;
        if (k == 7) begin l1 = 5; v1 = 12'h123; l2 = 40; v2 = 12'h456; end
        if (k == NCYC - 1) run_next = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk_i);
            if (c == 0) begin
                exp_q.push_back('{run: run_cur, addr: pc_m});
                pushed++;
            end
            if (c == l1) begin
                pc_load_i = 1'b1; pc_load_val_i = v1; tgt_m = v1; lm = 1'b1;
            end else if (c == l2) begin
                pc_load_i = 1'b1; pc_load_val_i = v2; tgt_m = v2; lm = 1'b1;
            end else begin
                pc_load_i = 1'b0;
            end
            if (c == 56) run_i = run_next;
        end
        if (lm) pc_m = tgt_m;
        else if (run_cur) pc_m = pc_m + 12'd1;
        lm = 1'b0;
        run_cur = run_next;
    endtask

    task automatic release_reset();
        pc_m = PC_RST; lm = 1'b0; run_cur = 1'b1; run_i = 1'b1; pc_load_i = 1'b0;
        RESET_N_i = 1'b1;
        repeat (8) @(negedge clk_i);
    endtask

    initial begin
        RESET_N_i = 1'b0; run_i = 1'b1; pc_load_i = 1'b0; pc_load_val_i = 12'h0;
        repeat (3) @(negedge clk_i);
        chk("rst_phi1", PHI1_o, 0);
        chk("rst_phi2", PHI2_o, 0);
        chk("rst_sync", SYNC_o, 0);
        chk("rst_cm", CM_o, 0);
        chk("rst_oe", D_oe_o, 0);
        chk("rst_d", D_o, 0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_opr", opr_o, 0);
        chk("rst_opa", opa_o, 0);
        chk("rst_pc", pc_o, PC_RST);

        release_reset();
        for (int k = 0; k < NCYC; k++) drive_cycle(k);

        // asynchronous reset in the middle of A2 of a fetch cycle
        @(negedge clk_i);
        pc_load_i = 1'b0;
        repeat (9) @(negedge clk_i);
        chk("a2_oe_before_reset", D_oe_o, 1);
        chk("a2_phi1_before_reset", PHI1_o, 1);
        #2 RESET_N_i = 1'b0;
        #1;
        chk("midrst_oe", D_oe_o, 0);
        chk("midrst_phi1", PHI1_o, 0);
        chk("midrst_phi2", PHI2_o, 0);
        chk("midrst_d", D_o, 0);
        chk("midrst_pc", pc_o, PC_RST);
        repeat (2) @(negedge clk_i);

        release_reset();
        for (int k = 0; k < 3; k++) drive_cycle(k);

        chk("records_checked", popped, pushed);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
